fetch_seq: RTL and testbench

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/cr16_pkg.sv | 36 +++
 rtl/pc_reg.sv | 37 +++
 rtl/fetch_seq.sv | 104 ++++++++++
 tb/tb_fetch_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cr16_pkg.sv
// Shared CR16 definitions: sequencer states, memory-opcode constants and classifier.
// Imported by the fetch sequencer and the instruction decoder.
package cr16_pkg;

  localparam int unsigned InstrWidth = 16;

  localparam logic [7:0] OpLoad = 8'h40;
  localparam logic [7:0] OpStor = 8'h44;

  typedef enum logic [2:0] {
    StFetch,
    StWait,
    StExec,
    StMem,
    StMemWb
  } fetch_state_e;

  typedef enum logic [1:0] {
    ClsOther,
    ClsLoad,
    ClsStor
  } instr_cls_e;

  // Takes the {instr[15:12], instr[7:4]} code; anything unrecognised is non-memory.
  function automatic instr_cls_e classify(logic [7:0] code);
    instr_cls_e cls;
    cls = ClsOther;
    if (code == OpLoad) begin
      cls = ClsLoad;
    end else if (code == OpStor) begin
      cls = ClsStor;
    end
    return cls;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: async reset to ResetPc, then either +1 or a loaded target on en_i.
// Increment wraps naturally at the register width.
module pc_reg
  import cr16_pkg::*;
#(
  parameter logic [InstrWidth-1:0] ResetPc = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  load_i,
  input  logic [InstrWidth-1:0] target_i,
  output logic [InstrWidth-1:0] pc_o
);

  localparam logic [InstrWidth-1:0] PcOne = InstrWidth'(1);

  logic [InstrWidth-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (en_i) begin
      pc_d = load_i ? target_i : pc_q + PcOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= ResetPc;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch/execute sequencer: FETCH -> WAIT -> EXEC [-> MEM [-> MEMWB]].
// Strobes are decoded from the current state and suppressed while stalled or in reset.
module fetch_seq
  import cr16_pkg::*;
#(
  parameter logic [InstrWidth-1:0] RESET_PC = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic [InstrWidth-1:0] mem_rdata,
  input  logic                  pc_load,
  input  logic [InstrWidth-1:0] pc_target,
  output logic [InstrWidth-1:0] mem_addr,
  output logic                  en_A,
  output logic [InstrWidth-1:0] instr,
  output logic                  instr_valid,
  output logic [InstrWidth-1:0] pc,
  output logic                  en_IR,
  output logic                  en_PC,
  output logic                  en_MAR,
  output logic                  en_MDR,
  output logic                  en_B,
  output logic                  mem_wb
);

  fetch_state_e          state_d, state_q;
  logic [InstrWidth-1:0] ir_d, ir_q;
  logic                  refetch_d, refetch_q;
  instr_cls_e            cls;
  logic                  run;

  assign cls = classify({ir_q[15:12], ir_q[7:4]});
  assign run = rst_n & ~stall;

  // A stall while waiting on the BRAM invalidates the pending read; remember it so
  // that the release goes back through FETCH instead of latching stale data.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    refetch_d = refetch_q;
    if (stall) begin
      if (state_q == StWait) begin
        refetch_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        StFetch: state_d = StWait;
        StWait: begin
          if (refetch_q) begin
            state_d   = StFetch;
            refetch_d = 1'b0;
          end else begin
            ir_d    = mem_rdata;
            state_d = StExec;
          end
        end
        StExec:  state_d = (cls == ClsOther) ? StFetch : StMem;
        StMem:   state_d = (cls == ClsLoad) ? StMemWb : StFetch;
        StMemWb: state_d = StFetch;
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      refetch_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      refetch_q <= refetch_d;
    end
  end

  always_comb begin
    en_A        = run & (state_q == StFetch);
    en_IR       = run & (state_q == StWait) & ~refetch_q;
    instr_valid = run & (state_q == StExec);
    en_PC       = run & (state_q == StExec);
    en_MAR      = run & (state_q == StMem);
    en_B        = run & (state_q == StMem);
    en_MDR      = run & (state_q == StMem) & (cls == ClsStor);
    mem_wb      = run & (state_q == StMemWb);
  end

  // pc_load only matters when en_PC is high, i.e. in an unstalled EXEC.
  pc_reg #(
    .ResetPc (RESET_PC)
  ) u_pc_reg (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .en_i     (en_PC),
    .load_i   (pc_load),
    .target_i (pc_target),
    .pc_o     (pc)
  );

  assign mem_addr = pc;
  assign instr    = ir_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: an instruction-level expectation queue checked every
// cycle, plus hand-computed literal checks at key points of the scenario.
module tb_fetch_seq;

  localparam logic [15:0] ResetPc = 16'h0000;

  // Strobe vector order: {en_A, en_IR, instr_valid, en_PC, en_MAR, en_MDR, en_B, mem_wb}
  localparam logic [7:0] VFetch = 8'b1000_0000;
  localparam logic [7:0] VWait  = 8'b0100_0000;
  localparam logic [7:0] VExec  = 8'b0011_0000;
  localparam logic [7:0] VMemL  = 8'b0000_1010;
  localparam logic [7:0] VMemS  = 8'b0000_1110;
  localparam logic [7:0] VWb    = 8'b0000_0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        pc_load = 1'b0;
  logic [15:0] pc_target = 16'h0000;
  logic [15:0] mem_addr, instr, pc;
  logic        en_A, instr_valid, en_IR, en_PC, en_MAR, en_MDR, en_B, mem_wb;

  int checks = 0;
  int errors = 0;

  fetch_seq #(
    .RESET_PC (ResetPc)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .mem_rdata   (mem_rdata),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .mem_addr    (mem_addr),
    .en_A        (en_A),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .en_IR       (en_IR),
    .en_PC       (en_PC),
    .en_MAR      (en_MAR),
    .en_MDR      (en_MDR),
    .en_B        (en_B),
    .mem_wb      (mem_wb)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] addr);
    case (addr)
      16'h0000: return 16'h5103;
      16'h0001: return 16'h4102;
      16'h0002: return 16'h4142;
      16'h0003: return 16'h5103;
      16'h0040: return 16'h5103;
      16'h0041: return 16'h4102;
      default:  return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (en_A) mem_rdata <= mem_word(mem_addr);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each instruction is a list of per-cycle strobe vectors derived from its opcode.
  logic [7:0]  plan_q[$];
  logic [15:0] m_pc = ResetPc;
  logic [15:0] m_ir = 16'h0000;

  task automatic push_plan(input logic [15:0] w);
    logic [7:0] code;
    code = {w[15:12], w[7:4]};
    plan_q.push_back(VFetch);
    plan_q.push_back(VWait);
    plan_q.push_back(VExec);
    if (code == 8'h40) begin
      plan_q.push_back(VMemL);
      plan_q.push_back(VWb);
    end else if (code == 8'h44) begin
      plan_q.push_back(VMemS);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] act_vec;
    logic [7:0] exp_vec;
    act_vec = {en_A, en_IR, instr_valid, en_PC, en_MAR, en_MDR, en_B, mem_wb};
    if (!rst_n) begin
      plan_q.delete();
      m_pc = ResetPc;
      m_ir = 16'h0000;
      check("reset_strobes", {8'h00, act_vec}, 16'h0000);
      check("reset_pc", pc, ResetPc);
      check("reset_instr", instr, 16'h0000);
    end else begin
      if (plan_q.size() == 0) push_plan(mem_word(m_pc));
      exp_vec = stall ? 8'h00 : plan_q[0];
      check("strobes", {8'h00, act_vec}, {8'h00, exp_vec});
      check("pc", pc, m_pc);
      check("mem_addr", mem_addr, m_pc);
      check("instr", instr, m_ir);
      if (stall) begin
        // Stall on the BRAM wait: one idle cycle after release, then a fresh fetch.
        if (plan_q[0][6]) begin
          plan_q.delete();
          plan_q.push_back(8'h00);
        end
      end else begin
        if (plan_q[0][6]) m_ir = mem_word(m_pc);
        if (plan_q[0][4]) m_pc = pc_load ? pc_target : m_pc + 16'd1;
        void'(plan_q.pop_front());
      end
    end
  end

  task automatic cyc(input logic s, input logic pl, input logic [15:0] tg);
    @(posedge clk);
    #1;
    stall     = s;
    pc_load   = pl;
    pc_target = tg;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("lit_rst_pc", pc, 16'h0000);
    check("lit_rst_instr", instr, 16'h0000);
    check("lit_rst_en_a", {15'd0, en_A}, 16'd0);

    cyc(0, 0, 0); rst_n = 1'b1;                         // C1 FETCH @0
    #1 check("lit_c1_en_a", {15'd0, en_A}, 16'd1);
    check("lit_c1_addr", mem_addr, 16'h0000);
    cyc(0, 0, 0); #1 check("lit_c2_en_ir", {15'd0, en_IR}, 16'd1);
    cyc(0, 0, 0); #1 check("lit_c3_instr", instr, 16'h5103);
    check("lit_c3_valid", {15'd0, instr_valid}, 16'd1);
    cyc(0, 0, 0); #1 check("lit_c4_pc", pc, 16'h0001);  // LOAD begins
    cyc(0, 0, 0);
    cyc(0, 0, 0); #1 check("lit_c6_instr", instr, 16'h4102);
    cyc(0, 0, 0); #1 check("lit_c7_mem_ld", {13'd0, en_MAR, en_B, en_MDR}, 16'b110);
    cyc(0, 0, 0); #1 check("lit_c8_mem_wb", {15'd0, mem_wb}, 16'd1);
    cyc(0, 0, 0); #1 check("lit_c9_fetch", {15'd0, en_A}, 16'd1);
    check("lit_c9_pc", pc, 16'h0002);                   // STOR begins
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0); #1 check("lit_c12_mem_st", {13'd0, en_MAR, en_B, en_MDR}, 16'b111);
    cyc(0, 0, 0); #1 check("lit_c13_fetch", {14'd0, en_A, mem_wb}, 16'b10);
    check("lit_c13_pc", pc, 16'h0003);
    cyc(0, 0, 0);
    cyc(0, 1, 16'h0040);                                // C15 EXEC jump
    cyc(0, 1, 16'h0777); #1 check("lit_c16_jump", mem_addr, 16'h0040);
    cyc(0, 1, 16'h0777);
    cyc(0, 0, 0);
    cyc(0, 0, 0); #1 check("lit_c19_no_load", mem_addr, 16'h0041);
    cyc(1, 0, 0);                                       // C20 WAIT stalled
    cyc(1, 0, 0); #1 check("lit_c21_stall_ir", {15'd0, en_IR}, 16'd0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0); #1 check("lit_c24_refetch", {15'd0, en_A}, 16'd1);
    check("lit_c24_addr", mem_addr, 16'h0041);
    cyc(0, 0, 0);
    cyc(0, 0, 0); #1 check("lit_c26_instr", instr, 16'h4102);
    cyc(0, 0, 0); #1 check("lit_c27_mem", {14'd0, en_MAR, en_B}, 16'b11);
    rst_n = 1'b0;
    #1 check("lit_c27_rst_pc", pc, ResetPc);
    check("lit_c27_rst_instr", instr, 16'h0000);
    check("lit_c27_rst_strb", {13'd0, en_MAR, en_B, mem_wb}, 16'd0);
    cyc(0, 0, 0); #1 check("lit_c28_no_wb", {15'd0, mem_wb}, 16'd0);
    cyc(0, 0, 0); rst_n = 1'b1;
    #1 check("lit_c29_fetch", {15'd0, en_A}, 16'd1);
    check("lit_c29_addr", mem_addr, ResetPc);
    cyc(0, 0, 0);
    cyc(1, 1, 16'h0040);                                // C31 stalled EXEC + pc_load
    cyc(0, 0, 0);
    cyc(0, 0, 0); #1 check("lit_c33_addr", mem_addr, 16'h0001);
    cyc(0, 0, 0);
    cyc(0, 1, 16'hFFFF);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0); #1 check("lit_c38_addr", mem_addr, 16'hFFFF);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0); #1 check("lit_c41_wrap", mem_addr, 16'h0000);
    repeat (5) cyc(0, 0, 0);
    cyc(1, 0, 0);                                       // C47 MEM stalled
    cyc(0, 0, 0);
    cyc(1, 0, 0);                                       // C49 MEMWB stalled
    cyc(0, 0, 0);
    cyc(0, 0, 0); #1 check("lit_c51_addr", mem_addr, 16'h0002);
    check("lit_c51_fetch", {15'd0, en_A}, 16'd1);
    repeat (3) cyc(0, 0, 0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
